// File: rtl/johnson_sequence_decoder.sv
// Johnson code monitor: validates and decodes a WIDTH-bit Johnson word to its index,
// tracks +1 step continuity with a lock FSM and keeps a saturating error count.
module johnson_sequence_decoder #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned IDX_WIDTH     = 4,
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     Clk_In,
    input  logic                     Reset_In,
    input  logic                     Enable_In,
    input  logic                     Sample_Valid_In,
    input  logic [WIDTH-1:0]         Johnson_Code_In,
    input  logic                     Clear_Error_Count_In,
    output logic [IDX_WIDTH-1:0]     Decoded_Index_Out,
    output logic                     Index_Valid_Out,
    output logic                     Code_Error_Out,
    output logic                     Step_Error_Out,
    output logic                     Locked_Flag_Out,
    output logic [ERR_CNT_WIDTH-1:0] Error_Count_Out
);

    localparam int unsigned SEQ_LEN = 2 * WIDTH;
    localparam int unsigned G_WIDTH = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [G_WIDTH-1:0]       good_q, good_d;
    logic [IDX_WIDTH-1:0]     idx_q, idx_d;
    logic                     valid_q, valid_d;
    logic                     code_err_q, code_err_d;
    logic                     step_err_q, step_err_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                     err_event;

    int unsigned              ones;
    logic [WIDTH-1:0]         lo_mask, hi_mask;
    logic                     legal;
    logic [IDX_WIDTH-1:0]     code_idx, next_idx;
    logic                     is_plus, is_hold;

    // Legal words are a run of ones anchored at bit 0 (MSB clear) or at the MSB (MSB set).
    always_comb begin
        ones    = 0;
        lo_mask = '0;
        hi_mask = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones = ones + 32'(Johnson_Code_In[i]);
        end
        for (int unsigned i = 0; i < WIDTH; i++) begin
            lo_mask[i] = (i < ones);
            hi_mask[i] = (i >= (WIDTH - ones));
        end
        legal    = Johnson_Code_In[WIDTH-1] ? (Johnson_Code_In == hi_mask)
                                            : (Johnson_Code_In == lo_mask);
        code_idx = Johnson_Code_In[WIDTH-1] ? IDX_WIDTH'(SEQ_LEN - ones)
                                            : IDX_WIDTH'(ones);
        next_idx = (idx_q == IDX_WIDTH'(SEQ_LEN - 1)) ? '0 : idx_q + IDX_WIDTH'(1);
        is_plus  = (code_idx == next_idx);
        is_hold  = (code_idx == idx_q);
    end

    // Next-state, index and pulse logic
    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        idx_d      = idx_q;
        valid_d    = 1'b0;
        code_err_d = 1'b0;
        step_err_d = 1'b0;
        err_event  = 1'b0;
        if (Sample_Valid_In) begin
            if (!legal) begin
                code_err_d = 1'b1;
                err_event  = 1'b1;
                state_d    = SEARCH;
                good_d     = '0;
            end else begin
                idx_d   = code_idx;
                valid_d = 1'b1;
                case (state_q)
                    SEARCH: begin
                        good_d  = '0;
                        state_d = TRACK;
                    end
                    TRACK: begin
                        if (is_plus) begin
                            good_d = good_q + G_WIDTH'(1);
                            if ((good_q + G_WIDTH'(1)) == G_WIDTH'(LOCK_COUNT)) begin
                                state_d = LOCKED;
                            end
                        end else if (!is_hold) begin
                            good_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (!is_plus && !is_hold) begin
                            step_err_d = 1'b1;
                            err_event  = 1'b1;
                            good_d     = '0;
                            state_d    = SEARCH;
                        end
                    end
                    default: begin
                        good_d  = '0;
                        state_d = SEARCH;
                    end
                endcase
            end
        end
        // Clear beats a same-edge error; otherwise count up to all-ones and hold.
        if (Clear_Error_Count_In) begin
            err_cnt_d = '0;
        end else if (err_event && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state_q    <= SEARCH;
            good_q     <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            code_err_q <= 1'b0;
            step_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            code_err_q <= code_err_d;
            step_err_q <= step_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Output enable gates only the drivers; internal state keeps running.
    assign Decoded_Index_Out = Enable_In ? idx_q                : 'z;
    assign Index_Valid_Out   = Enable_In ? valid_q              : 1'bz;
    assign Code_Error_Out    = Enable_In ? code_err_q           : 1'bz;
    assign Step_Error_Out    = Enable_In ? step_err_q           : 1'bz;
    assign Locked_Flag_Out   = Enable_In ? (state_q == LOCKED)  : 1'bz;
    assign Error_Count_Out   = Enable_In ? err_cnt_q            : 'z;

endmodule

// File: tb/tb_johnson_sequence_decoder.sv
// Directed bench for johnson_sequence_decoder: decode, lock, step/code errors, clear, enable, reset.
module tb_johnson_sequence_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sample;
    logic [7:0] code;
    logic       clear;
    wire  [3:0] idx;
    wire        valid;
    wire        code_err;
    wire        step_err;
    wire        locked;
    wire  [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

    johnson_sequence_decoder #(
        .WIDTH(8), .IDX_WIDTH(4), .LOCK_COUNT(4), .ERR_CNT_WIDTH(8)
    ) dut (
        .Clk_In              (clk),
        .Reset_In            (rst),
        .Enable_In           (en),
        .Sample_Valid_In     (sample),
        .Johnson_Code_In     (code),
        .Clear_Error_Count_In(clear),
        .Decoded_Index_Out   (idx),
        .Index_Valid_Out     (valid),
        .Code_Error_Out      (code_err),
        .Step_Error_Out      (step_err),
        .Locked_Flag_Out     (locked),
        .Error_Count_Out     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge, then settle just after the rising edge.
    task automatic cyc(input logic [7:0] c, input logic sv, input logic clr);
        @(negedge clk);
        code   = c;
        sample = sv;
        clear  = clr;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] walk [12];
    logic [7:0] relock [5];

    initial begin
        walk   = '{8'h3F, 8'h7F, 8'hFF, 8'hFE, 8'hFC, 8'hF8,
                   8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};
        relock = '{8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE};
        rst = 1'b1; en = 1'b1; sample = 1'b0; code = 8'h00; clear = 1'b0;

        // Reset state
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        check("rst_idx",   16'(idx),      16'h0);
        check("rst_valid", 16'(valid),    16'h0);
        check("rst_cerr",  16'(code_err), 16'h0);
        check("rst_serr",  16'(step_err), 16'h0);
        check("rst_lock",  16'(locked),   16'h0);
        check("rst_cnt",   16'(err_cnt),  16'h0);
        rst = 1'b0;

        // Acquire: seed then four +1 steps; lock appears on the fourth
        cyc(8'h01, 1'b1, 1'b0); check("acq_idx1", 16'(idx), 16'd1); check("acq_v1", 16'(valid), 16'h1); check("acq_l1", 16'(locked), 16'h0);
        cyc(8'h03, 1'b1, 1'b0); check("acq_idx2", 16'(idx), 16'd2); check("acq_l2", 16'(locked), 16'h0);
        cyc(8'h07, 1'b1, 1'b0); check("acq_idx3", 16'(idx), 16'd3); check("acq_l3", 16'(locked), 16'h0);
        cyc(8'h0F, 1'b1, 1'b0); check("acq_idx4", 16'(idx), 16'd4); check("acq_l4", 16'(locked), 16'h0);
        cyc(8'h1F, 1'b1, 1'b0); check("acq_idx5", 16'(idx), 16'd5); check("acq_v5", 16'(valid), 16'h1);
        check("acq_lock", 16'(locked), 16'h1);
        check("acq_cnt",  16'(err_cnt), 16'h0);

        // Idle cycle: pulses drop, index holds
        cyc(8'h55, 1'b0, 1'b0);
        check("idle_valid", 16'(valid),    16'h0);
        check("idle_idx",   16'(idx),      16'd5);
        check("idle_cerr",  16'(code_err), 16'h0);

        // Walk through the 15 -> 0 wrap while locked
        for (int i = 0; i < 12; i++) begin
            cyc(walk[i], 1'b1, 1'b0);
            check("walk_idx",  16'(idx),    16'((6 + i) % 16));
            check("walk_lock", 16'(locked), 16'h1);
        end
        // Holds are neutral
        for (int i = 0; i < 3; i++) begin
            cyc(8'h01, 1'b1, 1'b0);
            check("hold_idx",  16'(idx),      16'd1);
            check("hold_lock", 16'(locked),   16'h1);
            check("hold_serr", 16'(step_err), 16'h0);
        end
        check("hold_cnt", 16'(err_cnt), 16'h0);

        // Bad step while locked
        cyc(8'h0F, 1'b1, 1'b0);
        check("bad_idx",  16'(idx),      16'd4);
        check("bad_serr", 16'(step_err), 16'h1);
        check("bad_cnt",  16'(err_cnt),  16'd1);
        check("bad_lock", 16'(locked),   16'h0);
        // Re-seed plus four +1 steps to relock
        for (int i = 0; i < 5; i++) begin
            cyc(relock[i], 1'b1, 1'b0);
            check("relk_idx",  16'(idx),      16'(5 + i));
            check("relk_serr", 16'(step_err), 16'h0);
            check("relk_lock", 16'(locked),   16'(i == 4));
        end

        // Illegal code: index holds, count increments, lock drops
        cyc(8'h05, 1'b1, 1'b0);
        check("ill_cerr",  16'(code_err), 16'h1);
        check("ill_valid", 16'(valid),    16'h0);
        check("ill_idx",   16'(idx),      16'd9);
        check("ill_cnt",   16'(err_cnt),  16'd2);
        check("ill_lock",  16'(locked),   16'h0);
        // Clear wins over a same-edge error
        cyc(8'h05, 1'b1, 1'b1);
        check("clr_cerr", 16'(code_err), 16'h1);
        check("clr_cnt",  16'(err_cnt),  16'h0);

        // Saturation at all-ones, then a plain clear
        for (int i = 0; i < 260; i++) cyc(8'h05, 1'b1, 1'b0);
        check("sat_cnt", 16'(err_cnt), 16'hFF);
        cyc(8'h00, 1'b0, 1'b1);
        check("sat_clr", 16'(err_cnt), 16'h0);

        // Bad step in TRACK re-seeds silently
        cyc(8'h01, 1'b1, 1'b0); check("trk_idx1", 16'(idx), 16'd1);
        cyc(8'h0F, 1'b1, 1'b0);
        check("trk_idx",  16'(idx),      16'd4);
        check("trk_serr", 16'(step_err), 16'h0);
        check("trk_cnt",  16'(err_cnt),  16'h0);

        // Disabled outputs stop showing live values while decoding continues
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(relock[i], 1'b1, 1'b0);
            check("dis_idx_live",   16'(idx === 4'(5 + i)), 16'h0);
            check("dis_valid_live", 16'(valid === 1'b1),   16'h0);
        end
        @(negedge clk);
        sample = 1'b0;
        en = 1'b1;
        #1;
        check("reen_idx",   16'(idx),    16'd7);
        check("reen_valid", 16'(valid),  16'h1);
        check("reen_lock",  16'(locked), 16'h0);
        cyc(8'hFF, 1'b1, 1'b0);
        check("reen_relock", 16'(locked), 16'h1);
        check("reen_idx8",   16'(idx),    16'd8);

        // Reset mid-lock overrides a same-edge sample
        @(negedge clk);
        rst = 1'b1; code = 8'hFE; sample = 1'b1; clear = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_idx",   16'(idx),      16'h0);
        check("mrst_valid", 16'(valid),    16'h0);
        check("mrst_lock",  16'(locked),   16'h0);
        check("mrst_cerr",  16'(code_err), 16'h0);
        check("mrst_serr",  16'(step_err), 16'h0);
        check("mrst_cnt",   16'(err_cnt),  16'h0);
        rst = 1'b0;
        // Back in SEARCH: a fresh seed does not lock
        cyc(8'h03, 1'b1, 1'b0);
        check("post_idx",  16'(idx),    16'd2);
        check("post_lock", 16'(locked), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
